dcache_dm: RTL and testbench
============================

# dcache_dm

Parametrised direct-mapped, multi-word-block data cache between the CPU load/store stage and a word-wide backing memory port. Read hits return data combinationally. Read misses stall the core while an FSM fills the whole block from memory. Stores are write-through with no-write-allocate, support byte, half and word sizes, and stall until memory accepts them.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; fixed 32 in this generation, byte lanes = DATA_WIDTH/8
- INDEX_BITS, 4, log2 number of sets
- OFFSET_BITS, 2, log2 words per block
- TAG_BITS = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS-2 (derived localparam)

Ports:
- clk  in  1  rising-edge clock; one clock domain
- rst  in  1  synchronous, active-high reset
- A  in  ADDR_WIDTH  CPU byte address
- RE  in  1  load request
- WE  in  1  store request; RE and WE together = store wins
- WD  in  32  store data, right-aligned
- dataType  in  2  00 word, 01 byte, 10 halfword, 11 treated as word
- RD  out  32  load data, zero-extended for byte/half
- stall  out  1  hold CPU request stable while high
- mem_req  out  1  memory request valid
- mem_we  out  1  request is write
- mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0]=0)
- mem_wdata  out  32  lane-positioned store data
- mem_wstrb  out  4  byte enables
- mem_ready  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- Address split: tag A[top:INDEX+OFFSET+2], index, word offset, byte offset A[1:0]. Byte offset is used for lane select only.
- Line contents: valid bit, tag, and 2^OFFSET_BITS words. Valid bits are flops; data and tags are arrays.
- FSM states and transitions:
  - IDLE: on RE hit, RD = selected word shifted by A[1:0] and masked by dataType; stall=0.
  - IDLE: on RE miss, go to FILL with beat counter k=0.
  - IDLE: on WE, go to WRITE.
  - FILL: hold mem_req=1, mem_we=0, mem_addr={tag,index,k,2'b00} until mem_ready. Then wait for mem_rvalid, store the word in the line buffer, and increment k.
  - FILL: after the last beat, write the line with valid=1 and the new tag, then return to IDLE. The load re-evaluates as a hit on the next cycle.
  - WRITE: hold mem_req=1, mem_we=1, mem_wstrb per size/lane (byte 0001<<A[1:0], half 0011<<{A[1],0}, word 1111) until mem_ready, then return to IDLE.
  - WRITE: if the line hits, update only the strobed bytes of the cached word in the ready cycle. A store miss leaves the cache untouched.
- Misaligned half/word: low bits are ignored and the access is aligned down.
- The next request is accepted only in IDLE.

## Timing
- Reset values: all valids 0, state IDLE, k=0, RD=0, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0.
- Read hit: 0-cycle latency, no stall.
- stall is combinational. It is 1 in IDLE on a miss or store, and 1 throughout FILL/WRITE. It drops in the IDLE cycle that returns hit data.
- Miss latency with zero-wait memory (ready same cycle, rvalid next cycle): 2*2^OFFSET_BITS + 1 cycles until the hit.
- mem_rvalid outside FILL is ignored. mem_ready with mem_req=0 is ignored.
- rst mid-FILL or mid-WRITE: abandon the transaction, drop mem_req next cycle, invalidate all lines. The partial line is never marked valid.
- Store to the line currently being filled cannot occur, because stall blocks it.

## Configuration
- DCACHE_DM_STATS_EN defined:
  - Adds 32-bit outputs hit_count and miss_count, reset to 0.
  - hit_count increments once per completed load that hit in IDLE, excluding the replayed hit after a fill.
  - miss_count increments on each IDLE→FILL transition.
  - Both counters saturate at all-ones.
- DCACHE_DM_STATS_EN undefined: these ports and counters do not exist.

## Structure
- Package dcache_pkg holds:
  - dataType encodings (DT_WORD, DT_BYTE, DT_HALF)
  - FSM state enum (S_IDLE, S_FILL, S_WRITE)
  - line struct typedef helper
  - strobe and extract functions
- Sub-module dcache_lane_sel: combinational byte/half extraction and zero-extension for RD, plus strobe/wdata generation for stores.

## Test plan
- Reset, then load 0x100 (mem word 0x100=0xDEADBEEF, zero-wait memory) → stall 9 cycles, 4 read beats at 0x100..0x10C, then RD=0xDEADBEEF. A following load of 0x104 hits with stall=0.
- Byte load at 0x103 after the fill → RD=0x000000DE. Half load at 0x102 → RD=0x0000DEAD.
- Byte store 0x55 to 0x101 (hit) → mem_wstrb=0010, mem_wdata=0x00005500. Next load of 0x100 returns 0xDEAD55EF.
- Store to uncached 0x800 → one write beat, no fill. Subsequent load of 0x800 misses and fills.
- Conflict: load 0x100, then 0x200 (same index 0, different tag), then 0x100 → three misses.
- rst asserted during the second fill beat → mem_req=0 next cycle. Re-loading 0x100 misses. mem_rvalid after reset has no effect.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and lane helpers for the direct-mapped write-through data cache.
// Encodings for load/store size, FSM states, store lane payload and lane functions.
package dcache_pkg;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned LANES     = WORD_BITS / 8;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_BYTE = 2'b01;
  localparam logic [1:0] DT_HALF = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Lane-positioned store payload as presented to the memory port.
  typedef struct packed {
    logic [WORD_BITS-1:0] data;
    logic [LANES-1:0]     strb;
  } store_t;

  // Misaligned half/word accesses are aligned down by ignoring the low bits.
  function automatic logic [LANES-1:0] strobe(input logic [1:0] dt, input logic [1:0] boff);
    case (dt)
      DT_BYTE: return 4'b0001 << boff;
      DT_HALF: return 4'b0011 << {boff[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [WORD_BITS-1:0] extract(input logic [WORD_BITS-1:0] word,
                                                   input logic [1:0] dt,
                                                   input logic [1:0] boff);
    logic [WORD_BITS-1:0] sh;
    case (dt)
      DT_BYTE: begin
        sh = word >> {boff, 3'b000};
        return {24'h0, sh[7:0]};
      end
      DT_HALF: begin
        sh = word >> {boff[1], 4'h0};
        return {16'h0, sh[15:0]};
      end
      default: return word;
    endcase
  endfunction

  function automatic store_t place(input logic [WORD_BITS-1:0] wd,
                                   input logic [1:0] dt,
                                   input logic [1:0] boff);
    store_t s;
    s.strb = strobe(dt, boff);
    case (dt)
      DT_BYTE: s.data = {24'h0, wd[7:0]} << {boff, 3'b000};
      DT_HALF: s.data = {16'h0, wd[15:0]} << {boff[1], 4'h0};
      default: s.data = wd;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dcache_dm_if.sv
// CPU load/store port and word-wide memory port of the data cache.
// slave is the cache's view; master is the view of the core plus memory around it.
interface dcache_dm_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   A;
  logic                    RE;
  logic                    WE;
  logic [DATA_WIDTH-1:0]   WD;
  logic [1:0]              dataType;
  logic [DATA_WIDTH-1:0]   RD;
  logic                    stall;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic                    mem_ready;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  A, RE, WE, WD, dataType, mem_ready, mem_rvalid, mem_rdata,
    output RD, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output A, RE, WE, WD, dataType, mem_ready, mem_rvalid, mem_rdata,
    input  RD, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dcache_lane_sel.sv
// Byte/half lane selection: zero-extended load data and lane-positioned store data/strobes.
module dcache_lane_sel
  import dcache_pkg::*;
(
  input  logic [WORD_BITS-1:0] word,
  input  logic [WORD_BITS-1:0] wd,
  input  logic [1:0]           dt,
  input  logic [1:0]           boff,
  output logic [WORD_BITS-1:0] load_c,
  output store_t               store_c
);
  assign load_c  = extract(word, dt, boff);
  assign store_c = place(wd, dt, boff);
endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, multi-word-block, write-through/no-write-allocate data cache.
// Optional DCACHE_DM_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic clk,
  input  logic rst,
  dcache_dm_if.slave bus
`ifdef DCACHE_DM_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;
  localparam int unsigned IDX_LSB  = OFFSET_BITS + 2;
  localparam int unsigned TAG_LSB  = IDX_LSB + INDEX_BITS;
  localparam int unsigned SETS     = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << OFFSET_BITS;
  localparam int unsigned NLANES   = DATA_WIDTH / 8;

  logic [TAG_BITS-1:0]    tag;
  logic [INDEX_BITS-1:0]  idx;
  logic [OFFSET_BITS-1:0] woff;

  logic [SETS-1:0]        valid;
  logic [TAG_BITS-1:0]    tags [SETS];
  logic [DATA_WIDTH-1:0]  data [SETS][WORDS];

  state_t                 state;
  logic [OFFSET_BITS-1:0] k;
  logic                   wait_rv;
  logic                   replay;

  logic                   hit;
  logic [DATA_WIDTH-1:0]  cached_word;
  logic [DATA_WIDTH-1:0]  merged;
  logic [DATA_WIDTH-1:0]  load_c;
  store_t                 store_c;
  logic                   fill_we;
  logic                   store_we;

  assign tag  = bus.A[ADDR_WIDTH-1:TAG_LSB];
  assign idx  = bus.A[TAG_LSB-1:IDX_LSB];
  assign woff = bus.A[IDX_LSB-1:2];

  assign hit         = valid[idx] && (tags[idx] == tag);
  assign cached_word = data[idx][woff];

  dcache_lane_sel u_lane_sel (
    .word    (cached_word),
    .wd      (bus.WD),
    .dt      (bus.dataType),
    .boff    (bus.A[1:0]),
    .load_c  (load_c),
    .store_c (store_c)
  );

  // replay marks the IDLE cycle that completes the request just serviced by FILL/WRITE.
  assign bus.RD    = (state == S_IDLE && bus.RE && !bus.WE && hit) ? load_c : '0;
  assign bus.stall = (state != S_IDLE) || (bus.WE && !replay) || (bus.RE && !bus.WE && !hit);

  always_comb begin
    merged = cached_word;
    for (int i = 0; i < NLANES; i++) begin
      if (bus.mem_wstrb[i]) merged[8*i +: 8] = bus.mem_wdata[8*i +: 8];
    end
  end

  assign fill_we  = (state == S_FILL) && wait_rv && bus.mem_rvalid && !rst;
  assign store_we = (state == S_WRITE) && bus.mem_ready && hit && !rst;

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data[idx][k] <= bus.mem_rdata;
      tags[idx]    <= tag;
    end else if (store_we) begin
      data[idx][woff] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      k             <= '0;
      wait_rv       <= 1'b0;
      replay        <= 1'b0;
      valid         <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
    end else begin
      replay <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.WE && !replay) begin
            state         <= S_WRITE;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= {bus.A[ADDR_WIDTH-1:2], 2'b00};
            bus.mem_wdata <= store_c.data;
            bus.mem_wstrb <= store_c.strb;
          end else if (bus.RE && !bus.WE && !hit) begin
            state        <= S_FILL;
            k            <= '0;
            wait_rv      <= 1'b0;
            valid[idx]   <= 1'b0;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= {bus.A[ADDR_WIDTH-1:IDX_LSB], {OFFSET_BITS{1'b0}}, 2'b00};
          end
        end
        S_FILL: begin
          if (!wait_rv) begin
            if (bus.mem_ready) begin
              bus.mem_req <= 1'b0;
              wait_rv     <= 1'b1;
            end
          end else if (bus.mem_rvalid) begin
            wait_rv <= 1'b0;
            if (k == OFFSET_BITS'(WORDS - 1)) begin
              valid[idx] <= 1'b1;
              k          <= '0;
              replay     <= 1'b1;
              state      <= S_IDLE;
            end else begin
              k            <= OFFSET_BITS'(k + 1'b1);
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= {bus.A[ADDR_WIDTH-1:IDX_LSB], OFFSET_BITS'(k + 1'b1), 2'b00};
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            replay      <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_DM_STATS_EN
  logic hit_evt;
  logic miss_evt;

  assign hit_evt  = (state == S_IDLE) && bus.RE && !bus.WE && hit && !replay;
  assign miss_evt = (state == S_IDLE) && bus.RE && !bus.WE && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_evt && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (miss_evt && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: zero-wait memory model, vector table of loads/stores, beat scoreboard,
// plus hand sequences for reset values and reset during a fill.
module tb_dcache_dm;
  import dcache_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    string       name;
    bit          re;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  dt;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stall;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } vec_t;

  logic clk;
  logic rst;
  logic stray_rv;
  logic rv_q;
  logic [31:0] rdata_q;

  dcache_dm_if bus ();

`ifdef DCACHE_DM_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_dm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DCACHE_DM_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: always ready, read data one cycle after acceptance.
  bit [31:0] arr [1024];
  bit        written [1024];
  beat_t     beat_log [128];
  int        beat_n = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (written[a[11:2]]) return arr[a[11:2]];
    return init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  assign bus.mem_ready  = 1'b1;
  assign bus.mem_rvalid = rv_q | stray_rv;
  assign bus.mem_rdata  = rdata_q;

  always @(posedge clk) begin
    rv_q    <= bus.mem_req && bus.mem_ready && !bus.mem_we;
    rdata_q <= memval(bus.mem_addr);
    if (bus.mem_req && bus.mem_ready) begin
      beat_log[beat_n % 128] <= {bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata};
      beat_n <= beat_n + 1;
      if (bus.mem_we) begin
        arr[bus.mem_addr[11:2]]     <= merge(memval(bus.mem_addr), bus.mem_wdata, bus.mem_wstrb);
        written[bus.mem_addr[11:2]] <= 1'b1;
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          rd_ptr = 0;
  beat_t       exp_q[$];
  logic [31:0] rd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_beats(input string name);
    beat_t e;
    beat_t a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_ptr >= beat_n) begin
        errors++;
        $display("FAIL %s_beat actual=none expected addr=%h we=%0b", name, e.addr, e.we);
      end else begin
        a = beat_log[rd_ptr % 128];
        rd_ptr++;
        if (a.we !== e.we || a.addr !== e.addr ||
            (e.we && (a.strb !== e.strb || a.wdata !== e.wdata))) begin
          errors++;
          $display("FAIL %s_beat actual we=%0b addr=%h strb=%h wdata=%h expected we=%0b addr=%h strb=%h wdata=%h",
                   name, a.we, a.addr, a.strb, a.wdata, e.we, e.addr, e.strb, e.wdata);
        end
      end
    end
    chk({name, "_extra_beats"}, 32'(beat_n - rd_ptr), 32'd0);
    rd_ptr = beat_n;
  endtask

  task automatic push_fill(input logic [31:0] a, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b = {1'b0, {a[31:4], 4'h0} + 32'(4 * i), 4'h0, 32'h0};
      exp_q.push_back(b);
    end
  endtask

  task automatic run_op(input vec_t v);
    int          n;
    bit          done;
    logic [31:0] exp;
    beat_t       b;
    bus.A        = v.addr;
    bus.dataType = v.dt;
    bus.WD       = v.wd;
    bus.RE       = v.re;
    bus.WE       = v.we;
    exp          = '0;
    if (v.we) begin
      b = {1'b1, {v.addr[31:2], 2'b00}, v.strb, v.wdata};
      exp_q.push_back(b);
    end else begin
      if (v.stall > 0) push_fill(v.addr, 4);
      rd_q.push_back(v.rd);
    end
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!bus.stall) done = 1'b1;
      else n++;
    end
    if (!v.we) exp = rd_q.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=stall_stuck expected=stall_drop", v.name);
    end else begin
      chk({v.name, "_stall_cycles"}, 32'(n), 32'(v.stall));
      if (!v.we) chk({v.name, "_rd"}, bus.RD, exp);
    end
    @(posedge clk);
    #1;
    bus.RE = 1'b0;
    bus.WE = 1'b0;
    check_beats(v.name);
  endtask

  function automatic vec_t ld(input string n, input logic [31:0] a, input logic [1:0] dt,
                              input logic [31:0] rd, input int st);
    vec_t v;
    v.name = n; v.re = 1'b1; v.we = 1'b0; v.addr = a; v.dt = dt; v.wd = '0;
    v.rd = rd; v.stall = st; v.strb = '0; v.wdata = '0;
    return v;
  endfunction

  function automatic vec_t sto(input string n, input bit re, input logic [31:0] a,
                               input logic [1:0] dt, input logic [31:0] wd,
                               input logic [3:0] strb, input logic [31:0] wdata);
    vec_t v;
    v.name = n; v.re = re; v.we = 1'b1; v.addr = a; v.dt = dt; v.wd = wd;
    v.rd = '0; v.stall = 2; v.strb = strb; v.wdata = wdata;
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    vecs[0]  = ld ("lw100",     32'h100, DT_WORD, 32'hDEADBEEF, 9);
    vecs[1]  = ld ("lw104",     32'h104, DT_WORD, 32'h0104FEFB, 0);
    vecs[2]  = ld ("lb103",     32'h103, DT_BYTE, 32'h000000DE, 0);
    vecs[3]  = ld ("lh102",     32'h102, DT_HALF, 32'h0000DEAD, 0);
    vecs[4]  = sto("sb101",     1'b0, 32'h101, DT_BYTE, 32'h00000055, 4'b0010, 32'h00005500);
    vecs[5]  = ld ("lw100_upd", 32'h100, DT_WORD, 32'hDEAD55EF, 0);
    vecs[6]  = sto("sh10a_rw",  1'b1, 32'h10A, DT_HALF, 32'h0000BEEF, 4'b1100, 32'hBEEF0000);
    vecs[7]  = ld ("lw108",     32'h108, DT_WORD, 32'hBEEFFEF7, 0);
    vecs[8]  = sto("sh10f_mis", 1'b0, 32'h10F, DT_HALF, 32'hFFFF1234, 4'b1100, 32'h12340000);
    vecs[9]  = ld ("lh10d_mis", 32'h10D, DT_HALF, 32'h0000FEF3, 0);
    vecs[10] = ld ("lb10e",     32'h10E, DT_BYTE, 32'h00000034, 0);
    vecs[11] = ld ("lw104_dt3", 32'h104, 2'b11,   32'h0104FEFB, 0);
    vecs[12] = sto("sw800",     1'b0, 32'h800, DT_WORD, 32'h12345678, 4'b1111, 32'h12345678);
    vecs[13] = ld ("lw800",     32'h800, DT_WORD, 32'h12345678, 9);
    vecs[14] = ld ("lw200",     32'h200, DT_WORD, 32'h0200FDFF, 9);
    vecs[15] = ld ("lw100_re",  32'h100, DT_WORD, 32'hDEAD55EF, 9);
    vecs[16] = ld ("lb10f",     32'h10F, DT_BYTE, 32'h00000012, 0);

    rst          = 1'b1;
    stray_rv     = 1'b0;
    bus.A        = '0;
    bus.RE       = 1'b0;
    bus.WE       = 1'b0;
    bus.WD       = '0;
    bus.dataType = DT_WORD;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_stall",     32'(bus.stall),     32'd0);
    chk("rst_rd",        bus.RD,             32'd0);
    chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_mem_addr",  bus.mem_addr,       32'd0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,      32'd0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_op(vecs[i]);

`ifdef DCACHE_DM_STATS_EN
    chk("hit_count",  hit_count,  32'd9);
    chk("miss_count", miss_count, 32'd4);
`endif

    // Reset during the second fill beat of a conflicting load
    begin
      bit found;
      bus.A        = 32'h300;
      bus.dataType = DT_WORD;
      bus.RE       = 1'b1;
      push_fill(32'h300, 2);
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
        @(negedge clk);
        if (bus.mem_req && bus.mem_addr == 32'h304) found = 1'b1;
      end
      chk("rst_fill_window", 32'(found), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      bus.RE = 1'b0;
      @(negedge clk);
      chk("rst_fill_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_fill_stall",   32'(bus.stall),   32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      stray_rv = 1'b1;
      @(posedge clk);
      #1;
      stray_rv = 1'b0;
      @(negedge clk);
      chk("stray_rv_mem_req", 32'(bus.mem_req), 32'd0);
      @(posedge clk);
      #1;
      check_beats("rst_fill");
`ifdef DCACHE_DM_STATS_EN
      chk("rst_hit_count",  hit_count,  32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
`endif
      run_op(ld("lw100_after_rst", 32'h100, DT_WORD, 32'hDEAD55EF, 9));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
